mlp_result_streamer: RTL and testbench

Parametrised readout engine for the MLP accelerator's final-layer result matrix. On a start pulse it serialises a DIM×DIM matrix of signed DW-bit elements into LANES-wide packed words, in either row-major or column-major order, with an optional ReLU clamp. It sits between the accelerator's output register array and the host result port, and it adds valid/ready backpressure, a last-beat marker and a completion pulse.

---
 rtl/mlp_result_streamer.sv | 133 +++++++++++++
 tb/tb_mlp_result_streamer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mlp_result_streamer.sv
// Result readout engine: serialises a DIM x DIM signed matrix into LANES-wide beats
// (row- or column-major, optional ReLU) with valid/ready, last marker and done pulse.
module mlp_result_streamer #(
    parameter int DIM   = 16,
    parameter int DW    = 16,
    parameter int LANES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    col_major_i,
    input  logic                    relu_i,
    input  logic [DIM*DIM*DW-1:0]   mat_i,
    input  logic                    result_ready_i,
    output logic                    result_valid_o,
    output logic [LANES*DW-1:0]     result_payload_o,
    output logic                    result_last_o,
    output logic                    busy_o,
    output logic                    done_o
);

    localparam int BEATS = DIM * DIM / LANES;
    localparam int BPL   = DIM / LANES;
    localparam int KW    = $clog2(BEATS);
    localparam logic [KW-1:0] K_LAST = KW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            col_major_q;
    logic            relu_q;
    logic [LANES*DW-1:0] next_payload;

    // The beat loaded at the next edge: beat 0 with the incoming modes when idle,
    // otherwise beat k+1 with the latched modes.
    always_comb begin
        int            beat;
        int            major;
        int            minor;
        int            row;
        int            col;
        logic          use_col;
        logic          use_relu;
        logic [DW-1:0] elem;

        // NOTE: every variable gets a value before any branch so no latch is inferred.
        next_payload = '0;
        beat         = 0;
        major        = 0;
        minor        = 0;
        row          = 0;
        col          = 0;
        elem         = '0;
        use_col      = col_major_q;
        use_relu     = relu_q;

        if (state == IDLE) begin
            use_col  = col_major_i;
            use_relu = relu_i;
        end else begin
            beat = int'(k) + 1;
        end
        if (beat >= BEATS) begin
            beat = 0;
        end

        for (int l = 0; l < LANES; l++) begin
            major = beat / BPL;
            minor = (beat % BPL) * LANES + l;
            row   = use_col ? minor : major;
            col   = use_col ? major : minor;
            elem  = mat_i[(row * DIM + col) * DW +: DW];
            if (use_relu && elem[DW-1]) begin
                elem = '0;
            end
            next_payload[l * DW +: DW] = elem;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its peers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            k                <= '0;
            col_major_q      <= 1'b0;
            relu_q           <= 1'b0;
            result_valid_o   <= 1'b0;
            result_payload_o <= '0;
            result_last_o    <= 1'b0;
            busy_o           <= 1'b0;
            done_o           <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state            <= STREAM;
                        k                <= '0;
                        col_major_q      <= col_major_i;
                        relu_q           <= relu_i;
                        result_valid_o   <= 1'b1;
                        result_payload_o <= next_payload;
                        result_last_o    <= 1'b0;
                        busy_o           <= 1'b1;
                    end
                end
                STREAM: begin
                    if (result_valid_o && result_ready_i) begin
                        if (k == K_LAST) begin
                            state          <= IDLE;
                            k              <= '0;
                            result_valid_o <= 1'b0;
                            result_last_o  <= 1'b0;
                            busy_o         <= 1'b0;
                            done_o         <= 1'b1;
                        end else begin
                            k                <= k + 1'b1;
                            result_payload_o <= next_payload;
                            result_last_o    <= (k == K_LAST - 1'b1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_result_streamer.sv
// Directed bench for mlp_result_streamer: default instance plus a DIM=8/LANES=4/DW=8 instance.
module tb_mlp_result_streamer;

    localparam int BEATS = 128;
    localparam int BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i, col_major_i, relu_i, ready;
    logic [4095:0] mat;
    logic          valid, last, busy, done;
    logic [31:0]   payload;

    logic          start2, ready2, col2, relu2;
    logic [511:0]  mat8;
    logic          valid2, last2, busy2, done2;
    logic [31:0]   payload2;

    logic [15:0]   e [16][16];
    logic [31:0]   got_beats [BEATS];
    bit            stream_col, stream_relu;
    int            n_vec = 0;
    int            n_miss = 0;
    int            na, nv;

    always #5 clk = ~clk;

    mlp_result_streamer dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .col_major_i(col_major_i),
        .relu_i(relu_i), .mat_i(mat), .result_ready_i(ready),
        .result_valid_o(valid), .result_payload_o(payload), .result_last_o(last),
        .busy_o(busy), .done_o(done)
    );

    mlp_result_streamer #(.DIM(8), .DW(8), .LANES(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .col_major_i(col2),
        .relu_i(relu2), .mat_i(mat8), .result_ready_i(ready2),
        .result_valid_o(valid2), .result_payload_o(payload2), .result_last_o(last2),
        .busy_o(busy2), .done_o(done2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_mat();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                mat[(r * 16 + c) * 16 +: 16] = e[r][c];
    endtask

    function automatic logic [31:0] model_beat(input int kk, input bit col, input bit relu);
        logic [31:0] b;
        logic [15:0] v;
        int major, minor;
        b = '0;
        major = kk / 8;
        for (int l = 0; l < 2; l++) begin
            minor = (kk % 8) * 2 + l;
            v = col ? e[minor][major] : e[major][minor];
            if (relu && v[15]) v = '0;
            b[l * 16 +: 16] = v;
        end
        return b;
    endfunction

    task automatic begin_stream(input bit col, input bit relu);
        start_i = 1'b1;
        col_major_i = col;
        relu_i = relu;
        stream_col = col;
        stream_relu = relu;
        ready = 1'b1;
        step();
        start_i = 1'b0;
        col_major_i = 1'b0;
        relu_i = 1'b0;
    endtask

    // Consumes an active stream until valid drops; optionally pokes start mid-stream
    // or on the last beat, and optionally throttles ready randomly.
    task automatic drain(input bit rnd, input int inj_at, input bit start_last,
                         output int n_acc, output int n_valid);
        int cyc = 0;
        int model_err = 0, stall_err = 0, busy_err = 0, last_err = 0;
        bit prev_stall = 1'b0;
        logic [31:0] prev_p = '0;
        logic prev_last = 1'b0;
        n_acc = 0;
        n_valid = 0;
        while (valid && cyc < BUDGET) begin
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i = 1'b0;
            col_major_i = 1'b0;
            if ((inj_at >= 0 && n_acc == inj_at) || (start_last && n_acc == BEATS - 1)) begin
                start_i = 1'b1;
                col_major_i = 1'b1;
            end
            n_valid++;
            if (!busy) busy_err++;
            if (prev_stall && (payload !== prev_p || last !== prev_last)) stall_err++;
            if (ready) begin
                if (n_acc < BEATS) begin
                    got_beats[n_acc] = payload;
                    if (payload !== model_beat(n_acc, stream_col, stream_relu)) model_err++;
                end else begin
                    model_err++;
                end
                if (last !== (n_acc == BEATS - 1)) last_err++;
                n_acc++;
            end
            prev_stall = !ready;
            prev_p = payload;
            prev_last = last;
            step();
            cyc++;
        end
        start_i = 1'b0;
        col_major_i = 1'b0;
        ready = 1'b1;
        check("drain_timeout", 64'(cyc < BUDGET), 64'(1));
        check("model_seq", 64'(model_err), 64'(0));
        check("stall_hold", 64'(stall_err), 64'(0));
        check("busy_high", 64'(busy_err), 64'(0));
        check("last_flag", 64'(last_err), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt8, last_at8, cyc8;
        logic [31:0] first8, final8;

        rst_n = 1'b0;
        start_i = 1'b0; col_major_i = 1'b0; relu_i = 1'b0; ready = 1'b1;
        start2 = 1'b0; ready2 = 1'b1; col2 = 1'b0; relu2 = 1'b0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                e[r][c] = 16'(r * 16 + c);
        pack_mat();
        for (int i = 0; i < 64; i++) mat8[i * 8 +: 8] = 8'(i);

        #12;
        check("reset_outs", 64'({valid, payload, last, busy, done}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Row-major, ready tied high
        begin_stream(1'b0, 1'b0);
        check("row_start", 64'({busy, valid, done}), 64'(3'b110));
        drain(1'b0, -1, 1'b0, na, nv);
        check("row_accepted", 64'(na), 64'(128));
        check("row_valid_cycles", 64'(nv), 64'(128));
        check("row_beat0", 64'(got_beats[0]), 64'(32'h0001_0000));
        check("row_beat1", 64'(got_beats[1]), 64'(32'h0003_0002));
        check("row_beat127", 64'(got_beats[127]), 64'(32'h00FF_00FE));
        check("row_done_pulse", 64'({done, valid, busy}), 64'(3'b100));
        step();
        check("row_done_clear", 64'(done), 64'(0));

        // Column-major
        begin_stream(1'b1, 1'b0);
        drain(1'b0, -1, 1'b0, na, nv);
        check("col_accepted", 64'(na), 64'(128));
        check("col_beat0", 64'(got_beats[0]), 64'(32'h0010_0000));
        check("col_beat8", 64'(got_beats[8]), 64'(32'h0011_0001));
        check("col_beat127", 64'(got_beats[127]), 64'(32'h00FF_00EF));
        step();

        // Random backpressure, row-major
        begin_stream(1'b0, 1'b0);
        drain(1'b1, -1, 1'b0, na, nv);
        check("bp_accepted", 64'(na), 64'(128));
        check("bp_beat127", 64'(got_beats[127]), 64'(32'h00FF_00FE));
        check("bp_done", 64'(done), 64'(1));
        step();

        // ReLU on/off
        e[0][0] = 16'hFFFB;
        e[0][1] = 16'h7FFF;
        pack_mat();
        begin_stream(1'b0, 1'b1);
        check("relu_on_beat0", 64'(payload), 64'(32'h7FFF_0000));
        drain(1'b0, -1, 1'b0, na, nv);
        step();
        begin_stream(1'b0, 1'b0);
        check("relu_off_beat0", 64'(payload), 64'(32'h7FFF_FFFB));
        drain(1'b0, -1, 1'b0, na, nv);
        step();
        e[0][0] = 16'h0000;
        e[0][1] = 16'h0001;
        pack_mat();

        // Asynchronous reset mid-stream
        begin_stream(1'b0, 1'b0);
        repeat (40) step();
        rst_n = 1'b0;
        #1;
        check("async_reset_outs", 64'({valid, payload, last, busy, done}), 64'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        begin_stream(1'b0, 1'b0);
        check("restart_beat0", 64'(payload), 64'(32'h0001_0000));
        drain(1'b0, -1, 1'b0, na, nv);
        check("restart_accepted", 64'(na), 64'(128));
        step();

        // start with col_major=1 during a row-major stream is ignored
        begin_stream(1'b0, 1'b0);
        drain(1'b0, 10, 1'b0, na, nv);
        check("inj_accepted", 64'(na), 64'(128));
        check("inj_beat11", 64'(got_beats[11]), 64'(32'h0017_0016));
        step();

        // start on final handshake ignored; start with done accepted back-to-back
        begin_stream(1'b0, 1'b0);
        drain(1'b0, -1, 1'b1, na, nv);
        check("lastcyc_start_ignored", 64'({na, done, valid}), 64'({32'd128, 1'b1, 1'b0}));
        start_i = 1'b1;
        col_major_i = 1'b0;
        relu_i = 1'b0;
        stream_col = 1'b0;
        stream_relu = 1'b0;
        step();
        start_i = 1'b0;
        check("b2b_start", 64'({valid, busy, done}), 64'(3'b110));
        check("b2b_beat0", 64'(payload), 64'(32'h0001_0000));
        drain(1'b0, -1, 1'b0, na, nv);
        check("b2b_accepted", 64'(na), 64'(128));
        step();

        // Parameter sweep instance
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        first8 = payload2;
        cnt8 = 0;
        last_at8 = -1;
        cyc8 = 0;
        final8 = '0;
        while (valid2 && cyc8 < 100) begin
            if (last2) begin
                last_at8 = cnt8;
                final8 = payload2;
            end
            cnt8++;
            step();
            cyc8++;
        end
        check("p8_beat0", 64'(first8), 64'(32'h0302_0100));
        check("p8_beats", 64'(cnt8), 64'(16));
        check("p8_last_at", 64'(last_at8), 64'(15));
        check("p8_beat15", 64'(final8), 64'(32'h3F3E_3D3C));
        check("p8_done", 64'(done2), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
